// File: rtl/pattern_serializer.sv
// Serial bit-pattern generator: sends a captured pattern MSB-first, repeat_cnt+1 times,
// with optional idle gaps between repetitions and a done pulse after the final bit.
module pattern_serializer #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Start handshake: a request is taken at a rising edge when start_valid && start_ready.
    // start_ready is a pure function of state, so it never depends on start_valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             r_state, w_state_next;
    logic [PAT_W-1:0]   r_pat, w_pat_next;
    logic [PAT_W-1:0]   r_shift, w_shift_next;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic [CNT_W-1:0]   r_rep, w_rep_next;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_next;
    logic               r_x, w_x_next;
    logic               r_x_valid, w_x_valid_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;
    logic               w_last_bit;
    logic               w_gap_end;

    assign w_last_bit = (r_bit_cnt == BIT_W'(PAT_W - 1));
    assign w_gap_end  = (GAP > 0) && (int'(r_gap_cnt) == GAP - 1);

    // x holds the bit currently on the line; r_shift holds the bits still to follow.
    always_comb begin
        w_state_next   = r_state;
        w_pat_next     = r_pat;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_rep_next     = r_rep;
        w_gap_cnt_next = r_gap_cnt;
        w_x_next       = IDLE_BIT;
        w_x_valid_next = 1'b0;
        w_busy_next    = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_state_next   = S_SHIFT;
                    w_pat_next     = pattern;
                    w_rep_next     = repeat_cnt;
                    w_x_next       = pattern[PAT_W-1];
                    w_shift_next   = {pattern[PAT_W-2:0], 1'b0};
                    w_bit_cnt_next = '0;
                    w_x_valid_next = 1'b1;
                    w_busy_next    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!w_last_bit) begin
                    w_x_next       = r_shift[PAT_W-1];
                    w_shift_next   = {r_shift[PAT_W-2:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                    w_x_valid_next = 1'b1;
                    w_busy_next    = 1'b1;
                end else if (r_rep != '0) begin
                    w_rep_next  = r_rep - CNT_W'(1);
                    w_busy_next = 1'b1;
                    if (GAP > 0) begin
                        w_state_next   = S_GAP;
                        w_gap_cnt_next = '0;
                    end else begin
                        w_x_next       = r_pat[PAT_W-1];
                        w_shift_next   = {r_pat[PAT_W-2:0], 1'b0};
                        w_bit_cnt_next = '0;
                        w_x_valid_next = 1'b1;
                    end
                end else begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            S_GAP: begin
                w_busy_next = 1'b1;
                if (w_gap_end) begin
                    w_state_next   = S_SHIFT;
                    w_x_next       = r_pat[PAT_W-1];
                    w_shift_next   = {r_pat[PAT_W-2:0], 1'b0};
                    w_bit_cnt_next = '0;
                    w_x_valid_next = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_rep     <= '0;
            r_gap_cnt <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pat     <= w_pat_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_rep     <= w_rep_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_x       <= w_x_next;
            r_x_valid <= w_x_valid_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign x           = r_x;
    assign x_valid     = r_x_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: a back-to-back instance and a GAP=2 instance share stimulus;
// each is checked every cycle against a queue of expected line states built per frame.
module tb_pattern_serializer;

    typedef logic [3:0] ent_q_t[$];

    // Entry encoding: {x, x_valid, busy, done}
    localparam logic [3:0] E_IDLE = 4'b1000;
    localparam logic [3:0] E_DONE = 4'b1001;
    localparam logic [3:0] E_GAP  = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_valid;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;

    logic       rdy0, x0, xv0, busy0, done0;
    logic       rdy2, x2, xv2, busy2, done2;
    logic [1:0] st0, st2;

    int errors = 0;
    int checks = 0;

    ent_q_t     exp_q0;
    ent_q_t     exp_q2;
    logic [3:0] cur0 = E_IDLE;
    logic [3:0] cur2 = E_IDLE;

    int n_valid0, n_ones0, n_done0;

    always #5 clk = ~clk;

    pattern_serializer #(.PAT_W(4), .CNT_W(4), .GAP(0), .IDLE_BIT(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(rdy0),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .x(x0), .x_valid(xv0),
        .busy(busy0), .done(done0), .dbg_state(st0)
    );

    pattern_serializer #(.PAT_W(4), .CNT_W(4), .GAP(2), .IDLE_BIT(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(rdy2),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .x(x2), .x_valid(xv2),
        .busy(busy2), .done(done2), .dbg_state(st2)
    );

    // Full frame as seen on the line: rep+1 copies of the pattern MSB-first,
    // gap idles between copies, then the done cycle.
    function automatic ent_q_t build(input int gap, input logic [3:0] pat, input int rep);
        ent_q_t q;
        for (int r = 0; r <= rep; r++) begin
            for (int b = 3; b >= 0; b--) q.push_back({pat[b], 3'b110});
            if (r < rep) for (int g = 0; g < gap; g++) q.push_back(E_GAP);
        end
        q.push_back(E_DONE);
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check mid-cycle.
    task automatic step(input logic rst, input logic sv, input logic [3:0] pat, input logic [3:0] rep);
        reset       = rst;
        start_valid = sv;
        pattern     = pat;
        repeat_cnt  = rep;
        @(posedge clk);
        if (!rst) begin
            exp_q0.delete();
            exp_q2.delete();
            cur0 = E_IDLE;
            cur2 = E_IDLE;
        end else begin
            if (sv && !cur0[1]) exp_q0 = build(0, pat, int'(rep));
            if (sv && !cur2[1]) exp_q2 = build(2, pat, int'(rep));
            cur0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : E_IDLE;
            cur2 = (exp_q2.size() > 0) ? exp_q2.pop_front() : E_IDLE;
        end
        @(negedge clk);
        chk("g0_outputs", {28'd0, x0, xv0, busy0, done0}, {28'd0, cur0});
        chk("g0_ready", {31'd0, rdy0}, {31'd0, ~cur0[1]});
        chk("g2_outputs", {28'd0, x2, xv2, busy2, done2}, {28'd0, cur2});
        chk("g2_ready", {31'd0, rdy2}, {31'd0, ~cur2[1]});
        if (xv0) n_valid0++;
        if (xv0 && x0) n_ones0++;
        if (done0) n_done0++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    initial begin
        reset = 1'b0;
        start_valid = 1'b0;
        pattern = 4'h0;
        repeat_cnt = 4'h0;

        // Reset, including a start request that must be ignored under reset
        step(1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h6, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        idle(2);

        // Single frame, three back-to-back repetitions, one gapped pair
        step(1'b1, 1'b1, 4'b0110, 4'd0);
        idle(7);
        step(1'b1, 1'b1, 4'b0110, 4'd2);
        idle(20);
        step(1'b1, 1'b1, 4'b1010, 4'd1);
        idle(14);

        // Reset mid-frame, then a clean restart
        step(1'b1, 1'b1, 4'b0110, 4'd3);
        idle(1);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        idle(2);
        step(1'b1, 1'b1, 4'b1100, 4'd0);
        idle(7);

        // start_valid held with toggling pattern: ignored while busy, joined at done
        step(1'b1, 1'b1, 4'b0110, 4'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 4'b1001 : 4'b0101, 4'd0);
        idle(10);

        // Maximum repeat count
        n_valid0 = 0;
        n_ones0  = 0;
        n_done0  = 0;
        step(1'b1, 1'b1, 4'b0001, 4'hF);
        idle(100);
        chk("max_rep_bits", 32'(n_valid0), 32'd64);
        chk("max_rep_ones", 32'(n_ones0), 32'd16);
        chk("max_rep_done", 32'(n_done0), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Serial bit-pattern generator; the transmit-side counterpart of the team's serial sequence detector. Accepts a PAT_W-bit pattern and a repeat count through a valid/ready start handshake, then drives the pattern MSB-first on a 1-bit serial line, one bit per clock. It can insert optional idle gaps between repetitions and pulses done at the end. Used to stimulate or drive detector inputs, both in-system and on benches.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repeat-count input
GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back)
IDLE_BIT, 1, serial line level when not transmitting

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start_valid  input  1  request to start a transmission
start_ready  output  1  block can accept a request (high only in IDLE)
pattern  input  PAT_W  bits to send, MSB first; sampled only on handshake
repeat_cnt  input  CNT_W  transmissions = repeat_cnt+1
x  output  1  serial data out, registered
x_valid  output  1  high on cycles where x carries a pattern bit
busy  output  1  high in SHIFT or GAP
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset: reset=0 sampled at a rising edge: state IDLE, x=IDLE_BIT, x_valid=0, busy=0, done=0, start_ready=1, counters cleared. Applies mid-transfer; the in-flight frame is abandoned, no done pulse. start_valid is ignored in any cycle where reset=0.
- Handshake: accept when start_valid && start_ready at an edge. Capture pattern into shift register and repeat_cnt into rep counter. Inputs are ignored at all other times; changes to them while busy have no effect.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: x=IDLE_BIT, x_valid=0. On accept -> SHIFT.
- SHIFT: the first edge after accept presents pattern[PAT_W-1] on x with x_valid=1 (latency 1 cycle). Each following cycle presents the next lower bit. bit_cnt counts 0..PAT_W-1.
- After bit 0 of a repetition:
  - reps remaining and GAP>0 -> GAP.
  - reps remaining and GAP=0 -> reload captured pattern; next cycle presents MSB again (no bubble).
  - last rep -> IDLE with done=1 for exactly that cycle.
- GAP: x=IDLE_BIT, x_valid=0 for exactly GAP cycles, then SHIFT with MSB presented.
- Decrement the rep counter at the end of each repetition. Total serial cycles = (repeat_cnt+1)*PAT_W + repeat_cnt*GAP.
- start_ready=1 only in IDLE, including the done cycle. A start accepted in the done cycle produces its MSB on the next cycle, giving a gapless frame join.
- busy=1 from the cycle after accept through the last bit. busy=0 in the done cycle.
- repeat_cnt at max (all ones) = 2^CNT_W transmissions; the counter must not wrap early.
- All outputs registered. No combinational path from inputs to x, x_valid, busy or done. start_ready depends on state only.

Test Plan:
- pattern=4'b0110, repeat_cnt=0, accept at cycle T -> x=0,1,1,0 with x_valid=1 at T+1..T+4; done=1 at T+5 only; x=1, x_valid=0 after. With x driving the detector, z=1 during T+4 only.
- pattern=4'b0110, repeat_cnt=2, GAP=0 -> 12 contiguous bits 011001100110, done at T+13, detector z pulses 3 times (bits 4, 8, 12).
- GAP=2, pattern=4'b1010, repeat_cnt=1 -> 1010, two cycles of x=1/x_valid=0, 1010; done at T+11; busy high T+1..T+10.
- Reset (reset=0) at T+2 mid-frame -> next cycle x=IDLE_BIT, x_valid=0, busy=0, start_ready=1, no done. A new start after reset transmits cleanly from MSB.
- start_valid held high while busy with a different pattern -> ignored. Second frame accepted in the done cycle -> its MSB at done+1 with no idle bit. Pattern input toggled mid-frame -> output unchanged.
- repeat_cnt=4'hF, pattern=4'b0001 -> exactly 64 bits, 16 x_valid-qualified ones, single done pulse.
